// File: rtl/timing_pkg.sv
// Shared constants for the timing sequencer: default width, named timing
// indices and the per-edge control operation encoding.
package timing_pkg;

    localparam int SC_WIDTH = 4;

    localparam int T0  = 0;
    localparam int T1  = 1;
    localparam int T2  = 2;
    localparam int T3  = 3;
    localparam int T4  = 4;
    localparam int T5  = 5;
    localparam int T6  = 6;
    localparam int T7  = 7;
    localparam int T8  = 8;
    localparam int T9  = 9;
    localparam int T10 = 10;
    localparam int T11 = 11;
    localparam int T12 = 12;
    localparam int T13 = 13;
    localparam int T14 = 14;
    localparam int T15 = 15;

    // The single action resolved on each falling edge, after priority.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_LDERR,
        OP_INC,
        OP_WRAP,
        OP_SAT
    } seq_op_e;

endpackage

// File: rtl/timing_sequencer_if.sv
// Request/status bundle between a sequencer and its controller.
interface timing_sequencer_if #(
    parameter int WIDTH = timing_pkg::SC_WIDTH
);
    logic                clr;
    logic                inc;
    logic                ld;
    logic [WIDTH-1:0]    ld_val;
    logic [WIDTH-1:0]    count;
    logic [2**WIDTH-1:0] t;
    logic                tc;
    logic                wrap;
    logic                err;

    modport master (output clr, inc, ld, ld_val, input count, t, tc, wrap, err);
    modport slave  (input clr, inc, ld, ld_val, output count, t, tc, wrap, err);
endinterface

// File: rtl/seq_decoder.sv
// One-hot decode of the sequence count into timing signals T0..Tn.
// Bits above MAX are tied low since count can never reach them.
module seq_decoder
    import timing_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0]    count,
    output logic [2**WIDTH-1:0] t
);

    for (genvar i = 0; i < 2**WIDTH; i++) begin : g_bit
        if (i <= MAX) begin : g_live
            assign t[i] = (count == WIDTH'(i));
        end else begin : g_dead
            assign t[i] = 1'b0;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Falling-edge timing sequencer: prioritized clear/load/increment counter
// with wrap pulse, sticky illegal-load flag and one-hot timing outputs.
module timing_sequencer
    import timing_pkg::*;
#(
    parameter int WIDTH    = SC_WIDTH,
    parameter int MAX      = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0
) (
    input logic               clk,
    input logic               rst,
    timing_sequencer_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(T0);

    seq_op_e          op;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [2**WIDTH-1:0] t_w;

    // Resolve clr > ld > inc > hold into one operation, then its effect.
    always_comb begin
        op = OP_HOLD;
        if (bus.clr) begin
            op = OP_CLR;
        end else if (bus.ld) begin
            op = (bus.ld_val > MAX_V) ? OP_LDERR : OP_LOAD;
        end else if (bus.inc) begin
            if (count_q < MAX_V) op = OP_INC;
            else                 op = SATURATE ? OP_SAT : OP_WRAP;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        case (op)
            OP_CLR: begin
                count_d = ZERO_V;
                err_d   = 1'b0;
            end
            OP_LOAD:  count_d = bus.ld_val;
            OP_LDERR: err_d   = 1'b1;
            OP_INC:   count_d = count_q + WIDTH'(1);
            OP_WRAP: begin
                count_d = ZERO_V;
                wrap_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // State advances on the falling edge so it settles mid-cycle for the
    // rising-edge logic that consumes the timing signals.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO_V;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    seq_decoder #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_dec (
        .count (count_q),
        .t     (t_w)
    );

    assign bus.count = count_q;
    assign bus.t     = t_w;
    assign bus.tc    = (count_q == MAX_V);
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits; legal range 2..6.
REQ-002 Parameter MAX, default 2**WIDTH-1, SHALL set the terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0, SHALL select the mode at terminal count: 0 = wrap to zero, 1 = hold at MAX.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its falling edge, in line with the ASM chart timing.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 clr  input  1  SHALL be a synchronous clear request.
REQ-007 inc  input  1  SHALL be a synchronous increment request.
REQ-008 ld  input  1  SHALL be a synchronous load request.
REQ-009 ld_val  input  WIDTH  SHALL be the load value.
REQ-010 count  output  WIDTH  SHALL be the registered sequence value.
REQ-011 t  output  2**WIDTH  SHALL be the one-hot decode of count, with t[i] high when count==i (timing signals T0..Tn).
REQ-012 tc  output  1  SHALL be combinational and high when count==MAX.
REQ-013 wrap  output  1  SHALL be a registered one-cycle pulse marking a wrap from MAX to 0.
REQ-014 err  output  1  SHALL be a registered sticky flag for an illegal load.

Function
REQ-015 Control priority each falling edge SHALL be clr > ld > inc > hold; simultaneous requests SHALL be resolved by this order only.
REQ-016 clr=1 SHALL set count to 0 at the next falling edge, regardless of ld and inc.
REQ-017 ld=1 with clr=0 and ld_val<=MAX SHALL set count to ld_val at the next falling edge.
REQ-018 ld=1 with clr=0 and ld_val>MAX SHALL leave count unchanged and set err to 1 at that edge.
REQ-019 inc=1 with clr=0, ld=0 and count<MAX SHALL set count to count+1.
REQ-020 inc=1 with count==MAX and SATURATE=0 SHALL set count to 0 and assert wrap for exactly one cycle, until the following falling edge.
REQ-021 inc=1 with count==MAX and SATURATE=1 SHALL hold count at MAX and leave wrap low.
REQ-022 wrap SHALL be 0 on every edge where REQ-020 does not apply, including clr and ld edges.
REQ-023 No request (all of clr, ld, inc low) SHALL hold count; wrap SHALL go to 0.
REQ-024 t SHALL be exactly one-hot at all times; bits above MAX SHALL be constant 0.
REQ-025 Latency: count, t and tc SHALL reflect a request one falling edge after it is sampled; there SHALL be no combinational path from clr, ld or inc to any output.
REQ-026 err SHALL remain set until rst or clr; clr SHALL clear err at the same edge it clears count.
REQ-027 All arithmetic SHALL be WIDTH bits unsigned; no carry beyond WIDTH SHALL be observable.

Reset
REQ-028 rst=1 SHALL immediately and asynchronously force count=0, wrap=0 and err=0, giving t=1 (T0) and tc=(MAX==0 ? 1 : 0), i.e. 0 for all legal MAX.
REQ-029 Requests SHALL be ignored while rst=1; the first update after release SHALL occur on the first falling edge with rst=0.
REQ-030 Asserting rst mid-count SHALL abort the sequence with no wrap pulse.

Structure
REQ-031 Package timing_pkg SHALL hold the default WIDTH constant (SC_WIDTH=4) and the named timing index constants T0..T15.
REQ-032 One-hot decode SHALL be a sub-module seq_decoder (WIDTH in, 2**WIDTH out, MAX-masked); the counter and control SHALL stay in timing_sequencer.

Verification
REQ-033 rst pulse mid-count at count=5 -> count=0, t=16'h0001, wrap=0 immediately, without waiting for a clock edge.
REQ-034 WIDTH=4, MAX=15, SATURATE=0, inc held for 17 edges -> count 1..15, then 0, then 1; wrap high for exactly one cycle after the 0 edge; tc high only at 15.
REQ-035 MAX=9, SATURATE=1, inc held for 12 edges -> count stops at 9; tc=1; wrap never asserts.
REQ-036 clr=1, ld=1, inc=1 together at count=7 -> count=0; then ld=1, inc=1, ld_val=3 -> count=3 (load beats increment).
REQ-037 MAX=9, ld=1, ld_val=12 at count=4 -> count stays 4, err=1 and stays 1; a later clr -> err=0, count=0.
REQ-038 Random request stream of 1000 cycles -> t one-hot, t[count]==1 and t==1<<count on every cycle, checked against a reference model.
